// File: rtl/rv32i_pkg.sv
// Shared RV32I control-flow encodings and the 2-bit BHT counter type.
package rv32i_pkg;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;
   localparam logic [2:0] F3_JALR = 3'b000;

   typedef enum logic [1:0] {
      CLS_NONE   = 2'd0,
      CLS_BRANCH = 2'd1,
      CLS_JAL    = 2'd2,
      CLS_JALR   = 2'd3
   } ctl_cls_e;

   typedef logic [1:0] cnt2_t;

   localparam cnt2_t CNT_SNT = 2'b00;
   localparam cnt2_t CNT_WNT = 2'b01;
   localparam cnt2_t CNT_WT  = 2'b10;
   localparam cnt2_t CNT_STK = 2'b11;

   // Saturating step of a 2-bit direction counter.
   function automatic cnt2_t sat2_next(input cnt2_t cnt, input logic taken);
      cnt2_t nxt;
      nxt = cnt;
      if (taken) begin
         if (cnt != CNT_STK) nxt = cnt2_t'(cnt + 2'd1);
      end else begin
         if (cnt != CNT_SNT) nxt = cnt2_t'(cnt - 2'd1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/bht_sat2.sv
// Array of 2-bit saturating counters: one async read port, one sync write port.
module bht_sat2
   import rv32i_pkg::*;
#(
   parameter int unsigned ENTRIES = 64,
   parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [1:0]       rd_cnt,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_taken
);

   cnt2_t cnt_q [ENTRIES];
   cnt2_t cnt_d [ENTRIES];

   // No bypass: a read in the write cycle sees the pre-update counter.
   assign rd_cnt = cnt_q[rd_idx];

   always_comb begin
      cnt_d = cnt_q;
      if (wr_en) begin
         cnt_d[wr_idx] = sat2_next(cnt_q[wr_idx], wr_taken);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            cnt_q[i] <= CNT_WNT;
         end
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/branch_resolve_bht.sv
// Branch/jump resolution with a 1-cycle registered result and a 2-bit BHT
// trained by every accepted conditional branch with a legal funct3.
module branch_resolve_bht
   import rv32i_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned BHT_ENTRIES = 64,
   parameter int unsigned IDX_W       = $clog2(BHT_ENTRIES)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] lk_pc,
   output logic            lk_taken,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [9:0]      in_inst,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_imm,
   input  logic [XLEN-1:0] in_rs1_v,
   input  logic [XLEN-1:0] in_rs2_v,
   input  logic            in_pred_taken,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_taken,
   output logic            out_mispredict,
   output logic [XLEN-1:0] out_redirect_pc
);

   logic [6:0]      opcode_c;
   logic [2:0]      funct3_c;
   ctl_cls_e        cls_c;
   logic            eq_c, slt_c, ult_c;
   logic            cond_c, valid_f3_c;
   logic            taken_c, mispredict_c, train_c, accept_c;
   logic [XLEN-1:0] pc_tgt_c, jr_tgt_c, seq_pc_c, redirect_c;
   logic [1:0]      rd_cnt_c;
   logic            unused_bits_c;

   logic            out_valid_q, out_valid_d;
   logic            out_taken_q, out_taken_d;
   logic            out_mispredict_q, out_mispredict_d;
   logic [XLEN-1:0] out_redirect_pc_q, out_redirect_pc_d;

   assign opcode_c = in_inst[6:0];
   assign funct3_c = in_inst[9:7];

   assign eq_c  = (in_rs1_v == in_rs2_v);
   assign slt_c = ($signed(in_rs1_v) < $signed(in_rs2_v));
   assign ult_c = (in_rs1_v < in_rs2_v);

   assign pc_tgt_c = in_pc + in_imm;
   assign jr_tgt_c = (in_rs1_v + in_imm) & ~XLEN'(1);
   assign seq_pc_c = in_pc + XLEN'(4);

   // Instruction class; JALR with a non-zero funct3 is treated as non-control.
   always_comb begin
      cls_c = CLS_NONE;
      case (opcode_c)
         OP_BRANCH: cls_c = CLS_BRANCH;
         OP_JAL:    cls_c = CLS_JAL;
         OP_JALR:   cls_c = (funct3_c == F3_JALR) ? CLS_JALR : CLS_NONE;
         default:   cls_c = CLS_NONE;
      endcase
   end

   always_comb begin
      cond_c     = 1'b0;
      valid_f3_c = 1'b1;
      case (funct3_c)
         F3_BEQ:  cond_c = eq_c;
         F3_BNE:  cond_c = !eq_c;
         F3_BLT:  cond_c = slt_c;
         F3_BGE:  cond_c = !slt_c;
         F3_BLTU: cond_c = ult_c;
         F3_BGEU: cond_c = !ult_c;
         default: valid_f3_c = 1'b0;
      endcase
   end

   // JALR always redirects: there is no target prediction to confirm.
   always_comb begin
      taken_c      = 1'b0;
      redirect_c   = seq_pc_c;
      mispredict_c = in_pred_taken;
      train_c      = 1'b0;
      case (cls_c)
         CLS_BRANCH: begin
            taken_c      = cond_c;
            redirect_c   = cond_c ? pc_tgt_c : seq_pc_c;
            mispredict_c = cond_c ^ in_pred_taken;
            train_c      = valid_f3_c;
         end
         CLS_JAL: begin
            taken_c      = 1'b1;
            redirect_c   = pc_tgt_c;
            mispredict_c = !in_pred_taken;
         end
         CLS_JALR: begin
            taken_c      = 1'b1;
            redirect_c   = jr_tgt_c;
            mispredict_c = 1'b1;
         end
         default: begin
            taken_c = 1'b0;
         end
      endcase
   end

   assign in_ready = !out_valid_q || out_ready;
   assign accept_c = in_valid && in_ready && !flush;

   always_comb begin
      out_valid_d       = out_valid_q;
      out_taken_d       = out_taken_q;
      out_mispredict_d  = out_mispredict_q;
      out_redirect_pc_d = out_redirect_pc_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept_c) begin
         out_valid_d       = 1'b1;
         out_taken_d       = taken_c;
         out_mispredict_d  = mispredict_c;
         out_redirect_pc_d = redirect_c;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q       <= 1'b0;
         out_taken_q       <= 1'b0;
         out_mispredict_q  <= 1'b0;
         out_redirect_pc_q <= '0;
      end else begin
         out_valid_q       <= out_valid_d;
         out_taken_q       <= out_taken_d;
         out_mispredict_q  <= out_mispredict_d;
         out_redirect_pc_q <= out_redirect_pc_d;
      end
   end

   assign out_valid       = out_valid_q;
   assign out_taken       = out_taken_q;
   assign out_mispredict  = out_mispredict_q;
   assign out_redirect_pc = out_redirect_pc_q;

   bht_sat2 #(
      .ENTRIES (BHT_ENTRIES),
      .IDX_W   (IDX_W)
   ) u_bht (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_idx   (lk_pc[IDX_W+1:2]),
      .rd_cnt   (rd_cnt_c),
      .wr_en    (accept_c && train_c),
      .wr_idx   (in_pc[IDX_W+1:2]),
      .wr_taken (taken_c)
   );

   assign lk_taken = rd_cnt_c[1];

   assign unused_bits_c = ^{lk_pc[XLEN-1:IDX_W+2], lk_pc[1:0], rd_cnt_c[0]};

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed bench for branch_resolve_bht with a behavioural reference model.
module tb_branch_resolve_bht;

   localparam logic [9:0] I_BEQ  = {3'b000, 7'b1100011};
   localparam logic [9:0] I_BNE  = {3'b001, 7'b1100011};
   localparam logic [9:0] I_B010 = {3'b010, 7'b1100011};
   localparam logic [9:0] I_BLT  = {3'b100, 7'b1100011};
   localparam logic [9:0] I_BLTU = {3'b110, 7'b1100011};
   localparam logic [9:0] I_JAL  = {3'b000, 7'b1101111};
   localparam logic [9:0] I_JALR = {3'b000, 7'b1100111};
   localparam logic [9:0] I_ADD  = {3'b000, 7'b0110011};

   logic        clk, rst_n;
   logic [31:0] lk_pc;
   logic        lk_taken;
   logic        in_valid, in_ready;
   logic [9:0]  in_inst;
   logic [31:0] in_pc, in_imm, in_rs1_v, in_rs2_v;
   logic        in_pred_taken, flush;
   logic        out_valid, out_ready, out_taken, out_mispredict;
   logic [31:0] out_redirect_pc;

   int checks = 0;
   int errors = 0;

   branch_resolve_bht #(.XLEN(32), .BHT_ENTRIES(64)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .lk_pc           (lk_pc),
      .lk_taken        (lk_taken),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_inst         (in_inst),
      .in_pc           (in_pc),
      .in_imm          (in_imm),
      .in_rs1_v        (in_rs1_v),
      .in_rs2_v        (in_rs2_v),
      .in_pred_taken   (in_pred_taken),
      .flush           (flush),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_taken       (out_taken),
      .out_mispredict  (out_mispredict),
      .out_redirect_pc (out_redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: architectural outcome of one instruction.
   function automatic void resolve(input logic [9:0] inst, input logic [31:0] pc,
                                   input logic [31:0] imm, input logic [31:0] a,
                                   input logic [31:0] b, input logic pred,
                                   output logic tk, output logic mis,
                                   output logic [31:0] tgt, output logic trn);
      logic [6:0] op;
      logic [2:0] f3;
      op  = inst[6:0];
      f3  = inst[9:7];
      tk  = 1'b0;
      trn = 1'b0;
      tgt = pc + 32'd4;
      mis = pred;
      if (op == 7'b1100011) begin
         case (f3)
            3'd0: tk = (a == b);
            3'd1: tk = (a != b);
            3'd4: tk = ($signed(a) < $signed(b));
            3'd5: tk = ($signed(a) >= $signed(b));
            3'd6: tk = (a < b);
            3'd7: tk = (a >= b);
            default: tk = 1'b0;
         endcase
         trn = (f3 != 3'd2) && (f3 != 3'd3);
         if (tk) tgt = pc + imm;
         mis = (tk != pred);
      end else if (op == 7'b1101111) begin
         tk  = 1'b1;
         tgt = pc + imm;
         mis = !pred;
      end else if (op == 7'b1100111 && f3 == 3'd0) begin
         tk  = 1'b1;
         tgt = (a + imm) & 32'hFFFF_FFFE;
         mis = 1'b1;
      end
   endfunction

   int          m_bht [64];
   logic        m_valid, m_taken, m_mis, m_acc, m_tk, m_ms, m_trn;
   logic [31:0] m_pc, m_tgt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         foreach (m_bht[i]) m_bht[i] = 1;
         m_valid = 1'b0;
         m_taken = 1'b0;
         m_mis   = 1'b0;
         m_pc    = 32'd0;
      end else begin
         m_acc = in_valid && (!m_valid || out_ready) && !flush;
         if (flush) begin
            m_valid = 1'b0;
         end else if (m_acc) begin
            resolve(in_inst, in_pc, in_imm, in_rs1_v, in_rs2_v, in_pred_taken,
                    m_tk, m_ms, m_tgt, m_trn);
            m_valid = 1'b1;
            m_taken = m_tk;
            m_mis   = m_ms;
            m_pc    = m_tgt;
            if (m_trn) begin
               if (m_tk) m_bht[in_pc[7:2]] = (m_bht[in_pc[7:2]] >= 3) ? 3 : m_bht[in_pc[7:2]] + 1;
               else      m_bht[in_pc[7:2]] = (m_bht[in_pc[7:2]] <= 0) ? 0 : m_bht[in_pc[7:2]] - 1;
            end
         end else if (out_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   // Cycle compare against the model, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("in_ready",  32'(in_ready),  32'(!m_valid || out_ready));
         chk("out_valid", 32'(out_valid), 32'(m_valid));
         chk("lk_taken",  32'(lk_taken),  32'(m_bht[lk_pc[7:2]] >= 2));
         if (m_valid) begin
            chk("out_taken",       32'(out_taken),      32'(m_taken));
            chk("out_mispredict",  32'(out_mispredict), 32'(m_mis));
            chk("out_redirect_pc", out_redirect_pc,     m_pc);
         end
      end
   end

   task automatic present(input logic [9:0] inst, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] a, input logic [31:0] b, input logic pred);
      in_valid      = 1'b1;
      in_inst       = inst;
      in_pc         = pc;
      in_imm        = imm;
      in_rs1_v      = a;
      in_rs2_v      = b;
      in_pred_taken = pred;
   endtask

   task automatic issue(input logic [9:0] inst, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] a, input logic [31:0] b, input logic pred);
      present(inst, pc, imm, a, b, pred);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic chk_out(input string name, input logic tk, input logic mis, input logic [31:0] pc);
      chk({name, ".valid"},    32'(out_valid),      32'd1);
      chk({name, ".taken"},    32'(out_taken),      32'(tk));
      chk({name, ".mispred"},  32'(out_mispredict), 32'(mis));
      chk({name, ".redirect"}, out_redirect_pc,     pc);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      lk_pc = 32'd0; in_inst = '0; in_pc = '0; in_imm = '0;
      in_rs1_v = '0; in_rs2_v = '0; in_pred_taken = 1'b0;
      #12 rst_n = 1'b1;
      lk_pc = 32'h100;
      @(negedge clk);
      chk("rst.lk_taken",  32'(lk_taken),       32'd0);
      chk("rst.valid",     32'(out_valid),      32'd0);
      chk("rst.taken",     32'(out_taken),      32'd0);
      chk("rst.mispred",   32'(out_mispredict), 32'd0);
      chk("rst.redirect",  out_redirect_pc,     32'd0);
      @(posedge clk); #1;

      issue(I_BEQ, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0);
      chk_out("beq", 1'b1, 1'b1, 32'h120);
      chk("beq.lk", 32'(lk_taken), 32'd1);

      issue(I_BLT, 32'h104, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1);
      chk_out("blt", 1'b1, 1'b0, 32'h144);
      issue(I_BLTU, 32'h108, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1);
      chk_out("bltu", 1'b0, 1'b1, 32'h10C);
      issue(I_BEQ, 32'hFFFF_FFF0, 32'h20, 32'd7, 32'd7, 1'b1);
      chk_out("wrap", 1'b1, 1'b0, 32'h10);

      lk_pc = 32'h10C;
      issue(I_JALR, 32'h10C, 32'd4, 32'h1001, 32'd0, 1'b1);
      chk_out("jalr", 1'b1, 1'b1, 32'h1004);
      chk("jalr.lk", 32'(lk_taken), 32'd0);
      issue(I_JAL, 32'h110, 32'hFFFF_FFF8, 32'd0, 32'd0, 1'b1);
      chk_out("jal", 1'b1, 1'b0, 32'h108);
      issue(I_ADD, 32'h114, 32'h40, 32'd0, 32'd0, 1'b1);
      chk_out("alu", 1'b0, 1'b1, 32'h118);

      lk_pc = 32'h118;
      issue(I_B010, 32'h118, 32'h40, 32'd3, 32'd3, 1'b0);
      chk_out("f3_010", 1'b0, 1'b0, 32'h11C);
      issue(I_B010, 32'h118, 32'h40, 32'd3, 32'd3, 1'b0);
      issue(I_BEQ, 32'h118, 32'h40, 32'd3, 32'd3, 1'b0);
      chk("f3_010.untrained", 32'(lk_taken), 32'd1);

      // Same-index update and lookup in one cycle.
      lk_pc = 32'h11C;
      present(I_BEQ, 32'h11C, 32'h80, 32'd1, 32'd1, 1'b0);
      #2 chk("same_cycle.old", 32'(lk_taken), 32'd0);
      @(posedge clk); #1; in_valid = 1'b0;
      chk("sat.after1", 32'(lk_taken), 32'd1);
      issue(I_BEQ, 32'h11C, 32'h80, 32'd1, 32'd1, 1'b1);
      issue(I_BEQ, 32'h11C, 32'h80, 32'd1, 32'd1, 1'b1);
      issue(I_BEQ, 32'h11C, 32'h80, 32'd1, 32'd1, 1'b1);
      chk("sat.after4", 32'(lk_taken), 32'd1);
      issue(I_BNE, 32'h11C, 32'h80, 32'd1, 32'd1, 1'b1);
      chk_out("sat.nt", 1'b0, 1'b1, 32'h120);
      chk("sat.to_wt", 32'(lk_taken), 32'd1);
      issue(I_BNE, 32'h11C, 32'h80, 32'd1, 32'd1, 1'b1);
      chk("sat.to_wnt", 32'(lk_taken), 32'd0);

      // Backpressure: result held while a second instruction waits.
      issue(I_BEQ, 32'h130, 32'h10, 32'd1, 32'd2, 1'b0);
      out_ready = 1'b0;
      present(I_JAL, 32'h140, 32'h100, 32'd0, 32'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold.in_ready", 32'(in_ready), 32'd0);
         chk_out("hold", 1'b0, 1'b0, 32'h134);
      end
      out_ready = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      chk_out("hold.next", 1'b1, 1'b1, 32'h240);

      // Flush beats a same-cycle accept: no result, no training.
      lk_pc = 32'h120;
      present(I_BNE, 32'h120, 32'h10, 32'd9, 32'd9, 1'b0);
      flush = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
      chk("flush.valid", 32'(out_valid), 32'd0);
      chk("flush.lk",    32'(lk_taken),  32'd0);
      issue(I_BEQ, 32'h120, 32'h10, 32'd9, 32'd9, 1'b0);
      chk("flush.untrained", 32'(lk_taken), 32'd1);

      // Asynchronous reset while a result is held.
      lk_pc = 32'h11C;
      issue(I_BEQ, 32'h11C, 32'h80, 32'd1, 32'd1, 1'b0);
      out_ready = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("areset.valid",    32'(out_valid),   32'd0);
      chk("areset.redirect", out_redirect_pc,  32'd0);
      chk("areset.lk",       32'(lk_taken),    32'd0);
      #3 rst_n = 1'b1;
      out_ready = 1'b1;
      lk_pc = 32'h120;
      @(negedge clk);
      chk("areset.bht_cleared", 32'(lk_taken), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_resolve_bht.md
# branch_resolve_bht

Parametrised branch resolution unit for the RV32I core with an integrated branch history table (BHT) of 2-bit saturating counters. It sits between execute and the fetch redirect logic. The fetch stage reads a taken/not-taken prediction combinationally. The execute stage presents resolved branch/jump operands and receives a registered outcome, target, and mispredict/redirect one cycle later. The BHT is trained on every accepted conditional branch.

## Interface
- `XLEN`, 32: datapath width (rs values, PC, immediate, target).
- `BHT_ENTRIES`, 64: number of counters; power of two, 2..256.
- `IDX_W`, $clog2(BHT_ENTRIES): BHT index width (derived).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `lk_pc`  in  XLEN  fetch PC to predict.
- `lk_taken`  out  1  prediction for `lk_pc` (counter MSB); combinational.
- `in_valid`  in  1  execute presents an instruction.
- `in_ready`  out  1  unit can accept.
- `in_inst`  in  10  {funct3[2:0], opcode[6:0]}.
- `in_pc`  in  XLEN  instruction PC.
- `in_imm`  in  XLEN  sign-extended immediate.
- `in_rs1_v`, `in_rs2_v`  in  XLEN  operand values.
- `in_pred_taken`  in  1  prediction fetch used for this instruction.
- `flush`  in  1  kill the held result; no BHT effect this cycle.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer accepts.
- `out_taken`  out  1  resolved direction.
- `out_mispredict`  out  1  fetch must redirect.
- `out_redirect_pc`  out  XLEN  correct next PC (target if taken, else pc+4).

## Operation
- Opcode decode: 1100011 B-type; 1101111 JAL; 1100111 JALR (funct3 000 only); anything else is a non-control instruction.
- B-type funct3 conditions:
  - 000 beq: equal.
  - 001 bne: not equal.
  - 100 blt: signed less-than.
  - 101 bge: signed greater-or-equal.
  - 110 bltu: unsigned less-than.
  - 111 bgeu: unsigned greater-or-equal.
  - 010 and 011: not taken, no BHT update.
- JAL is always taken; target = pc + imm.
- JALR is always taken; target = (rs1 + imm) & ~1.
- B-type target = pc + imm. All sums are modulo 2^XLEN; wrap-around is silent.
- Non-control instructions: taken = 0, redirect = pc + 4; mispredict if pred_taken = 1.
- Mispredict = (taken != pred_taken) for B-type and JAL. For JALR it is taken || pred_taken, i.e. always 1: there is no target predictor.
- BHT index = pc[IDX_W+1:2] for both lookup and update.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Counter update: increment on taken, decrement on not taken, saturating at 11 and 00.
- Only valid-funct3 B-type instructions train the BHT. The update happens in the accept cycle (in_valid && in_ready && !flush).
- Lookup during an update to the same index returns the pre-update value; there is no bypass.

## Timing
- Latency 1: the result registers on the accept edge, and `out_*` is valid from the next cycle.
- in_ready = !out_valid || out_ready, so back-to-back accepts occur at full throughput when out_ready = 1.
- Outputs hold stable while out_valid && !out_ready.
- flush: out_valid clears next edge and any same-cycle input is dropped (no register load, no BHT update). flush dominates accept.
- Reset values:
  - out_valid 0; out_taken 0; out_mispredict 0; out_redirect_pc 0.
  - All BHT counters 01 (weak-NT), so lk_taken = 0 everywhere after reset.
- Reset asserted mid-operation discards the held result and all training, immediately and asynchronously.

## Structure
- A shared package `rv32i_pkg` holds:
  - opcode constants OP_BRANCH, OP_JAL, OP_JALR;
  - funct3 constants F3_BEQ..F3_BGEU;
  - the 2-bit counter type and its reset constant CNT_WNT.
- Sub-module `bht_sat2` holds the counter array, the asynchronous read port, and the single synchronous write port with saturating next-state.
- The comparator, target adders, and output register stay in the top level.

## Test plan
- Reset, then lk_pc = 0x100 → lk_taken = 0; all outputs 0.
- Accept beq at pc 0x100, imm 0x20, rs1 = rs2 = 5, pred 0 → next cycle out_taken = 1, out_mispredict = 1, out_redirect_pc = 0x120. Lookup of 0x100 then reads 1 (counter 10).
- blt with rs1 = 0xFFFFFFFF, rs2 = 1 → taken. The same operands as bltu → not taken, redirect pc+4. Also cover a pc+imm wrap: pc 0xFFFFFFF0, imm 0x20 → target 0x10.
- JALR with rs1 = 0x1001, imm 4, pred 1 → taken, target 0x1004, out_mispredict = 1. The BHT entry is unchanged.
- Four taken branches at the same PC saturate the counter at 11, and one not-taken then gives 10 (still predicts taken). Include an update and a lookup of that index in the same cycle: the lookup shows the old value.
- Backpressure and flush:
  - out_ready = 0 for 3 cycles: in_ready = 0, outputs stable.
  - Flush together with in_valid: out_valid = 0 next cycle, BHT unchanged.
  - Assert rst_n low mid-hold: out_valid drops without waiting for a clock edge.
